// File: rtl/pipe_stage_skid_reg_pkg.sv
// Shared types for the handshaked pipeline stage register: WB controls,
// stage payload layout, FSM state encoding and the XZR capture helper.
package pipe_stage_skid_reg_pkg;

    localparam int DATA_W_DEF    = 64;
    localparam int NUM_LANES_DEF = 2;
    localparam int RD_W_DEF      = 5;

    localparam logic [4:0] XZR_IDX = 5'd31;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } struct_WB;

    typedef struct packed {
        struct_WB                                    wb;
        logic [RD_W_DEF-1:0]                         rd;
        logic [NUM_LANES_DEF-1:0][DATA_W_DEF-1:0]    lanes;
    } struct_stage_payload;

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_e;

    function automatic struct_WB wb_capture(input struct_WB wb, input logic kill_write);
        struct_WB r;
        r = wb;
        if (kill_write) begin
            r.reg_write = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/pipe_stage_skid_reg_entry.sv
// One payload slot of the stage: enabled register with asynchronous
// active-low clear, generic in width.
module stage_entry_reg #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Handshaked pipeline stage register: N data lanes + rd + WB controls held in
// a main/skid pair so the stage can stall without dropping an accepted beat.
module pipe_stage_skid_reg
    import pipe_stage_skid_reg_pkg::*;
#(
    parameter int DATA_W       = 64,
    parameter int NUM_LANES    = 2,
    parameter int RD_W         = 5,
    parameter bit SKID_EN      = 1'b1,
    parameter bit XZR_SUPPRESS = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NUM_LANES*DATA_W-1:0] in_data,
    input  logic [RD_W-1:0]             in_rd,
    input  struct_WB                    in_wb,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NUM_LANES*DATA_W-1:0] out_data,
    output logic [RD_W-1:0]             out_rd,
    output struct_WB                    out_wb,
    output logic [1:0]                  occupancy,
    output logic [1:0]                  dbg_state_o
);

    localparam int LANES_W = NUM_LANES * DATA_W;
    localparam int PAY_W   = 2 + RD_W + LANES_W;

    stage_state_e     state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             accept, drain;
    logic             main_en, skid_en, main_from_skid;
    logic             is_xzr;
    logic [PAY_W-1:0] in_pay, main_d, main_q, skid_q;
    struct_WB         main_wb;

    // Handshake: a beat moves on a port only in a cycle where valid and ready
    // are both high at the rising edge; valid never waits on ready, and once
    // out_valid is up the presented payload holds until it drains.
    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    assign is_xzr = (XZR_SUPPRESS != 1'b0) && (in_rd == {RD_W{1'b1}});
    assign in_pay = {wb_capture(in_wb, is_xzr), in_rd, in_data};
    assign main_d = main_from_skid ? skid_q : in_pay;

    always_comb begin
        state_d        = state_q;
        main_en        = 1'b0;
        skid_en        = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_BUSY;
                        main_en = 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (accept && drain) begin
                        main_en = 1'b1;
                    end else if (accept && SKID_EN) begin
                        state_d = ST_FULL;
                        skid_en = 1'b1;
                    end else if (drain) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (drain) begin
                        state_d        = ST_BUSY;
                        main_en        = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    assign in_ready_d = (state_d != ST_FULL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    stage_entry_reg #(.W(PAY_W)) u_main (
        .clk_i  (clk),
        .rst_ni (rst),
        .en_i   (main_en),
        .d_i    (main_d),
        .q_o    (main_q)
    );

    stage_entry_reg #(.W(PAY_W)) u_skid (
        .clk_i  (clk),
        .rst_ni (rst),
        .en_i   (skid_en),
        .d_i    (in_pay),
        .q_o    (skid_q)
    );

    // Without the skid slot, a busy stage can only take a beat it drains at once.
    assign in_ready    = SKID_EN ? in_ready_q : (out_ready | ~out_valid);
    assign out_valid   = (state_q != ST_EMPTY);
    assign occupancy   = state_q;
    assign dbg_state_o = state_q;

    assign out_data = main_q[LANES_W-1:0];
    assign out_rd   = main_q[LANES_W +: RD_W];
    assign main_wb  = struct_WB'(main_q[PAY_W-1 -: 2]);

    // Flushed or drained entries keep their data but can never write back.
    assign out_wb.reg_write  = main_wb.reg_write & out_valid;
    assign out_wb.mem_to_reg = main_wb.mem_to_reg;

endmodule

// File: doc/pipe_stage_skid_reg.md
Name: pipe_stage_skid_reg

Overview:
- Parametrised, handshaked pipeline stage register for the 64-bit ARM pipeline; the generalised successor of the fixed MEM/WB latch.
- Carries N data lanes, a WB control struct and a destination register through a 2-entry skid buffer with valid/ready flow control.
- Supports flush (bubble insertion) and optional XZR write suppression.
- Drop-in for EX/MEM, MEM/WB, or any future stage that must stall without losing data.

Parameters:
- DATA_W, 64, width of each data lane.
- NUM_LANES, 2, number of data lanes (MEM/WB: lane0 = read_data, lane1 = ALU_result).
- RD_W, 5, destination register index width.
- SKID_EN, 1, 1 = 2-entry skid buffer; 0 = single entry, in_ready = out_ready | ~out_valid.
- XZR_SUPPRESS, 1, 1 = clear reg_write when rd == all-ones (X31/XZR).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous kill of all held entries.
- in_valid  input  1  upstream payload valid.
- in_ready  output  1  stage can accept; registered.
- in_data  input  NUM_LANES*DATA_W  lanes, lane k at [k*DATA_W +: DATA_W].
- in_rd  input  RD_W  destination register.
- in_wb  input  struct_WB  WB controls {reg_write, mem_to_reg}.
- out_valid  output  1  downstream payload valid.
- out_ready  input  1  downstream accepts.
- out_data  output  NUM_LANES*DATA_W  held lanes.
- out_rd  output  RD_W  held destination.
- out_wb  output  struct_WB  held WB controls.
- occupancy  output  2  number of held entries (0..2).

Behaviour:
- Reset (rst low, asynchronous): state EMPTY, out_valid 0, out_data/out_rd/out_wb 0, occupancy 0, in_ready 1. The skid entry is also cleared to 0.
- Transfer rules: accept = in_valid & in_ready; drain = out_valid & out_ready.
- Latency: one cycle from accept to out_valid when EMPTY. No combinational path exists from in_* to out_*, or from out_ready to in_ready.
- State machine (SKID_EN = 1):
  - EMPTY: accept -> BUSY (main <= in).
  - BUSY, accept & drain -> BUSY (main <= in).
  - BUSY, accept & ~drain -> FULL (skid <= in).
  - BUSY, ~accept & drain -> EMPTY.
  - BUSY, neither -> BUSY.
  - FULL (in_ready = 0): drain -> BUSY (main <= skid); otherwise hold.
- in_ready = (next_state != FULL), registered.
- out_valid = (state != EMPTY). occupancy is 0 / 1 / 2 for EMPTY / BUSY / FULL.
- Ordering: entries leave strictly in acceptance order. The skid entry is never presented before main.
- Flush: highest priority over all transitions.
  - Next state EMPTY, out_valid 0 next cycle, in_ready 1 next cycle.
  - Any in_valid in the flush cycle is discarded.
  - Data registers are not cleared; out_wb.reg_write is forced 0 so stale entries cannot write back.
- XZR suppression: when XZR_SUPPRESS = 1 and in_rd == {RD_W{1'b1}}, the captured reg_write = 0. Other fields are captured unchanged.
- Stall hold: while ~drain, all out_* are stable.
- in_valid deasserting with no accept has no effect.
- SKID_EN = 0:
  - States are EMPTY/BUSY only.
  - Accept while BUSY requires drain in the same cycle; in_ready becomes combinational (out_ready | ~out_valid).
  - occupancy is at most 1.
- Reset mid-operation: all entries are dropped immediately, independent of clk.

Decomposition:
- Package structures: struct_WB (existing); new typedef struct_stage_payload {struct_WB wb; logic [RD_W-1:0] rd; lanes}; localparam XZR_IDX = 5'd31.
- One sub-module, stage_entry_reg: a DATA_W-generic enabled register with async active-low clear. It is instantiated for main and skid.

Test Plan:
- Reset/basic pass: release rst; in_valid = 1, lane0 = 64'hDEAD_BEEF, lane1 = 64'h1, rd = 5, wb = 2'b11, out_ready = 1 -> next cycle out_valid = 1, out_data matches, out_wb = 2'b11, occupancy = 1.
- Backpressure: out_ready = 0; send A (rd = 1) then B (rd = 2) -> occupancy = 2, in_ready = 0, C is held off. Raise out_ready -> A, B, C emerge in order on consecutive cycles; in_ready returns to 1 after A drains.
- Flush while FULL: occupancy = 2; flush = 1 with in_valid = 1 (rd = 7) -> next cycle out_valid = 0, occupancy = 0, out_wb.reg_write = 0, in_ready = 1; rd = 7 never appears.
- XZR suppression: in_rd = 31, wb = 2'b11 -> out_wb = 2'b01. The same input with XZR_SUPPRESS = 0 -> out_wb = 2'b11.
- Async reset mid-stall: occupancy = 2; pull rst low between clock edges -> out_valid = 0, occupancy = 0, all outputs 0 before the next edge.
- Streaming throughput: in_valid and out_ready held at 1 for 100 cycles with an incrementing lane0 -> 100 outputs, one per cycle, with no gaps or duplicates. Repeat with SKID_EN = 0.
